// File: rtl/ext_io_mailbox.sv
// ext_io_mailbox: byte mailbox on the 6809 external I/O bus.
// The CPU writes the TX FIFO and reads the RX FIFO. The stream side drains TX and fills RX.
// MRDY stretches late E by WAIT CLKX4 cycles.
// All CPU side effects land on the commit edge: late E, selected, and the stretch has expired.

module ext_io_mailbox_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_full,
  output logic       o_empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;

  // Storage is not reset; the empty flag masks stale contents.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers and occupancy. The caller has already gated push on !full and pop on !empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_ONE;
      if (i_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_rdata = o_empty ? 8'h00 : r_mem[r_rptr];
endmodule

module ext_io_mailbox #(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [3:0] WAIT_RESET = 4'd0
) (
  input  logic       CLKX4,
  input  logic       nRESET,
  input  logic       E,
  input  logic       Q,
  input  logic [1:0] ADDR,
  input  logic       RnW,
  input  logic       nCSEXTIO,
  input  logic [7:0] DATA_in,
  output logic [7:0] DATA_out,
  output logic       DATA_oe,
  output logic       MRDY,
  output logic       nIRQ,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);
  logic       w_sel, w_commit, w_wr, w_rd;
  logic       w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic       w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  logic [7:0] w_rx_head;
  logic [3:0] r_wcnt, r_wait;
  logic       r_ovr, r_tx_irq_en, r_rx_irq_en;

  assign w_sel    = !nCSEXTIO;
  assign w_commit = !Q && E && w_sel && (r_wcnt == 4'd0);
  assign w_wr     = w_commit && !RnW;
  assign w_rd     = w_commit && RnW;

  // An overflowing write is judged on the pre-edge full flag, so a same-edge pop does not rescue it.
  assign w_tx_push = w_wr && (ADDR == 2'd0) && !w_tx_full;
  assign w_tx_pop  = !w_tx_empty && tx_ready;
  assign w_rx_push = rx_valid && !w_rx_full;
  assign w_rx_pop  = w_rd && (ADDR == 2'd0) && !w_rx_empty;

  ext_io_mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .i_clk(CLKX4), .i_rst_n(nRESET), .i_push(w_tx_push), .i_pop(w_tx_pop),
    .i_wdata(DATA_in), .o_rdata(tx_data), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  ext_io_mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .i_clk(CLKX4), .i_rst_n(nRESET), .i_push(w_rx_push), .i_pop(w_rx_pop),
    .i_wdata(rx_data), .o_rdata(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  // Stretch counter: loads in early E, then counts down through late E.
  always_ff @(posedge CLKX4 or negedge nRESET) begin
    if (!nRESET) begin
      r_wcnt <= 4'd0;
    end else if (Q && E && w_sel) begin
      r_wcnt <= r_wait;
    end else if (!Q && E && (r_wcnt != 4'd0)) begin
      r_wcnt <= r_wcnt - 4'd1;
    end
  end

  // Control and status registers, written only on the commit edge.
  always_ff @(posedge CLKX4 or negedge nRESET) begin
    if (!nRESET) begin
      r_ovr       <= 1'b0;
      r_tx_irq_en <= 1'b0;
      r_rx_irq_en <= 1'b0;
      r_wait      <= WAIT_RESET;
    end else if (w_wr) begin
      case (ADDR)
        2'd0: if (w_tx_full) r_ovr <= 1'b1;
        2'd1: if (DATA_in[7]) r_ovr <= 1'b0;
        2'd2: {r_tx_irq_en, r_rx_irq_en} <= DATA_in[1:0];
        default: r_wait <= DATA_in[3:0];
      endcase
    end
  end

  // Read mux. For DATA it returns the head before the commit-edge pop.
  always_comb begin
    DATA_out = 8'h00;
    case (ADDR)
      2'd0: DATA_out = w_rx_head;
      2'd1: DATA_out = {r_ovr, 3'b000, w_tx_full, w_tx_empty, w_rx_full, !w_rx_empty};
      2'd2: DATA_out = {6'b0, r_tx_irq_en, r_rx_irq_en};
      default: DATA_out = {4'b0, r_wait};
    endcase
  end

  assign DATA_oe  = E && RnW && w_sel;
  assign MRDY     = (r_wcnt == 4'd0);
  assign nIRQ     = !(r_ovr || (r_rx_irq_en && !w_rx_empty) || (r_tx_irq_en && w_tx_empty));
  assign rx_ready = !w_rx_full;
  assign tx_valid = !w_tx_empty;
endmodule

// File: tb/tb_ext_io_mailbox.sv
// Directed bench for ext_io_mailbox.
// A small bus model walks {Q,E} through 00,10,11,01 and holds 01 while MRDY is low, like the clock generator does.

module tb_ext_io_mailbox;
  logic       CLKX4 = 1'b0, nRESET = 1'b0, E = 1'b0, Q = 1'b0;
  logic [1:0] ADDR = 2'd1;
  logic       RnW = 1'b1, nCSEXTIO = 1'b1;
  logic [7:0] DATA_in = 8'h00, rx_data = 8'h00;
  logic       rx_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0] DATA_out, tx_data;
  logic       DATA_oe, MRDY, nIRQ, rx_ready, tx_valid;

  int n_pass = 0, n_total = 0;
  logic [7:0] rdv;
  int         st;
  logic       oe;

  ext_io_mailbox dut (
    .CLKX4(CLKX4), .nRESET(nRESET), .E(E), .Q(Q), .ADDR(ADDR), .RnW(RnW),
    .nCSEXTIO(nCSEXTIO), .DATA_in(DATA_in), .DATA_out(DATA_out), .DATA_oe(DATA_oe),
    .MRDY(MRDY), .nIRQ(nIRQ), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 CLKX4 = ~CLKX4;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One bus cycle. st counts late-E edges with MRDY low. rd/oe are sampled just before the commit edge.
  // With pop, tx_ready is high only across the commit edge.
  task automatic bus_cycle(input logic [1:0] a, input logic rnw, input logic [7:0] wd,
                           input logic pop, output logic [7:0] rd, output int stc, output logic oe_o);
    @(negedge CLKX4); ADDR = a; RnW = rnw; DATA_in = wd; nCSEXTIO = 1'b0; Q = 1'b1; E = 1'b0;
    @(negedge CLKX4); E = 1'b1;
    @(negedge CLKX4); Q = 1'b0;
    #1; stc = 0;
    while (MRDY !== 1'b1 && stc < 40) begin stc++; @(negedge CLKX4); #1; end
    if (stc >= 40) begin n_total++; $display("FAIL bus_timeout: MRDY got %b after %0d edges, required 1", MRDY, stc); end
    rd = DATA_out; oe_o = DATA_oe;
    if (pop) tx_ready = 1'b1;
    @(negedge CLKX4); E = 1'b0; nCSEXTIO = 1'b1; RnW = 1'b1; tx_ready = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus_cycle(a, 1'b0, d, 1'b0, rdv, st, oe);
  endtask

  task automatic rd(input logic [1:0] a);
    bus_cycle(a, 1'b1, 8'h00, 1'b0, rdv, st, oe);
  endtask

  task automatic test_reset;
    nRESET = 1'b0;
    repeat (3) @(negedge CLKX4);
    #1;
    n_total++; if (MRDY !== 1'b1) $display("FAIL rst_mrdy got %b exp 1", MRDY); else n_pass++;
    n_total++; if (nIRQ !== 1'b1) $display("FAIL rst_nirq got %b exp 1", nIRQ); else n_pass++;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid got %b exp 0", tx_valid); else n_pass++;
    n_total++; if (rx_ready !== 1'b1) $display("FAIL rst_rx_ready got %b exp 1", rx_ready); else n_pass++;
    n_total++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data got %h exp 00", tx_data); else n_pass++;
    ADDR = 2'd3; #1;
    n_total++; if (DATA_out !== 8'h00) $display("FAIL rst_wait_rd got %h exp 00", DATA_out); else n_pass++;
    ADDR = 2'd2; #1;
    n_total++; if (DATA_out !== 8'h00) $display("FAIL rst_ctrl_rd got %h exp 00", DATA_out); else n_pass++;
    @(negedge CLKX4); nRESET = 1'b1;
    rd(2'd1);
    // Only tx_empty is set after reset.
    n_total++; if (rdv !== 8'h04) $display("FAIL rst_status got %h exp 04", rdv); else n_pass++;
    n_total++; if (st !== 0) $display("FAIL rst_stretch got %0d exp 0", st); else n_pass++;
    n_total++; if (oe !== 1'b1) $display("FAIL rd_oe got %b exp 1", oe); else n_pass++;
  endtask

  task automatic test_wait_ctrl;
    wr(2'd3, 8'h03);
    n_total++; if (st !== 0) $display("FAIL wait_wr_stretch got %0d exp 0", st); else n_pass++;
    n_total++; if (oe !== 1'b0) $display("FAIL wr_oe got %b exp 0", oe); else n_pass++;
    rd(2'd1);
    n_total++; if (st !== 3) $display("FAIL wait3_stretch got %0d exp 3", st); else n_pass++;
    n_total++; if (rdv !== 8'h04) $display("FAIL wait3_status got %h exp 04", rdv); else n_pass++;
    wr(2'd3, 8'hF0);
    rd(2'd3);
    n_total++; if (rdv !== 8'h00) $display("FAIL wait_rd got %h exp 00", rdv); else n_pass++;
    n_total++; if (st !== 0) $display("FAIL wait0_stretch got %0d exp 0", st); else n_pass++;
    wr(2'd2, 8'hFF);
    rd(2'd2);
    n_total++; if (rdv !== 8'h03) $display("FAIL ctrl_rd got %h exp 03", rdv); else n_pass++;
    n_total++; if (nIRQ !== 1'b0) $display("FAIL tx_irq got %b exp 0", nIRQ); else n_pass++;
    wr(2'd2, 8'h00);
    n_total++; if (nIRQ !== 1'b1) $display("FAIL irq_off got %b exp 1", nIRQ); else n_pass++;
  endtask

  task automatic test_tx_overrun;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr(2'd0, 8'(i + 1));
    wr(2'd0, 8'hAA);
    rd(2'd1);
    n_total++; if (rdv !== 8'h88) $display("FAIL ovr_status got %h exp 88", rdv); else n_pass++;
    n_total++; if (nIRQ !== 1'b0) $display("FAIL ovr_nirq got %b exp 0", nIRQ); else n_pass++;
    @(negedge CLKX4); tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_total++; if (tx_data !== 8'(i + 1)) $display("FAIL tx_drain[%0d] got %h exp %h", i, tx_data, 8'(i + 1)); else n_pass++;
      @(negedge CLKX4);
    end
    tx_ready = 1'b0; #1;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL tx_drained got %b exp 0", tx_valid); else n_pass++;
    rd(2'd1);
    n_total++; if (rdv !== 8'h84) $display("FAIL ovr_kept got %h exp 84", rdv); else n_pass++;
    wr(2'd1, 8'h80);
    rd(2'd1);
    n_total++; if (rdv !== 8'h04) $display("FAIL ovr_clear got %h exp 04", rdv); else n_pass++;
    n_total++; if (nIRQ !== 1'b1) $display("FAIL ovr_clear_nirq got %b exp 1", nIRQ); else n_pass++;
  endtask

  task automatic test_rx_irq;
    wr(2'd2, 8'h01);
    n_total++; if (nIRQ !== 1'b1) $display("FAIL rx_irq_idle got %b exp 1", nIRQ); else n_pass++;
    @(negedge CLKX4); rx_data = 8'h5A; rx_valid = 1'b1;
    @(negedge CLKX4); rx_valid = 1'b0; #1;
    n_total++; if (nIRQ !== 1'b0) $display("FAIL rx_irq got %b exp 0", nIRQ); else n_pass++;
    rd(2'd0);
    n_total++; if (rdv !== 8'h5A) $display("FAIL rx_read got %h exp 5a", rdv); else n_pass++;
    n_total++; if (nIRQ !== 1'b1) $display("FAIL rx_irq_clr got %b exp 1", nIRQ); else n_pass++;
    rd(2'd1);
    n_total++; if (rdv !== 8'h04) $display("FAIL rx_single_pop got %h exp 04", rdv); else n_pass++;
    rd(2'd0);
    n_total++; if (rdv !== 8'h00) $display("FAIL rx_empty_read got %h exp 00", rdv); else n_pass++;
    wr(2'd2, 8'h00);
  endtask

  task automatic test_rx_full_pop;
    @(negedge CLKX4); rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin rx_data = 8'(8'h40 + i); @(negedge CLKX4); end
    rx_data = 8'hEE; #1;
    n_total++; if (rx_ready !== 1'b0) $display("FAIL rx_full_ready got %b exp 0", rx_ready); else n_pass++;
    rd(2'd1);
    n_total++; if (rdv !== 8'h07) $display("FAIL rx_full_status got %h exp 07", rdv); else n_pass++;
    rd(2'd0);
    rx_valid = 1'b0;
    n_total++; if (rdv !== 8'h40) $display("FAIL rx_full_pop got %h exp 40", rdv); else n_pass++;
    rd(2'd1);
    n_total++; if (rdv !== 8'h05) $display("FAIL rx_15_status got %h exp 05", rdv); else n_pass++;
    for (int i = 1; i < 16; i++) begin
      rd(2'd0);
      n_total++; if (rdv !== 8'(8'h40 + i)) $display("FAIL rx_drain[%0d] got %h exp %h", i, rdv, 8'(8'h40 + i)); else n_pass++;
    end
    rd(2'd0);
    n_total++; if (rdv !== 8'h00) $display("FAIL rx_no_push got %h exp 00", rdv); else n_pass++;
  endtask

  task automatic test_tx_concurrent;
    for (int i = 0; i < 16; i++) wr(2'd0, 8'(8'h20 + i));
    bus_cycle(2'd0, 1'b0, 8'hCC, 1'b1, rdv, st, oe);
    rd(2'd1);
    n_total++; if (rdv !== 8'h80) $display("FAIL tx_full_pushpop got %h exp 80", rdv); else n_pass++;
    bus_cycle(2'd0, 1'b0, 8'hDD, 1'b1, rdv, st, oe);
    rd(2'd1);
    n_total++; if (rdv !== 8'h80) $display("FAIL tx_pushpop_status got %h exp 80", rdv); else n_pass++;
    @(negedge CLKX4); tx_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      #1;
      n_total++;
      if (tx_data !== ((i < 14) ? 8'(8'h22 + i) : 8'hDD))
        $display("FAIL tx_cc_drain[%0d] got %h exp %h", i, tx_data, ((i < 14) ? 8'(8'h22 + i) : 8'hDD));
      else n_pass++;
      @(negedge CLKX4);
    end
    tx_ready = 1'b0; #1;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL tx_cc_count got %b exp 0", tx_valid); else n_pass++;
    wr(2'd1, 8'h80);
  endtask

  task automatic test_reset_mid_stretch;
    wr(2'd3, 8'h03);
    wr(2'd0, 8'h77);
    @(negedge CLKX4); rx_data = 8'h99; rx_valid = 1'b1;
    @(negedge CLKX4); rx_valid = 1'b0;
    ADDR = 2'd2; RnW = 1'b0; DATA_in = 8'h03; nCSEXTIO = 1'b0; Q = 1'b1; E = 1'b0;
    @(negedge CLKX4); E = 1'b1;
    @(negedge CLKX4); Q = 1'b0;
    @(negedge CLKX4); #1;
    n_total++; if (MRDY !== 1'b0) $display("FAIL mid_mrdy_low got %b exp 0", MRDY); else n_pass++;
    nRESET = 1'b0; #1;
    n_total++; if (MRDY !== 1'b1) $display("FAIL mid_rst_mrdy got %b exp 1", MRDY); else n_pass++;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL mid_rst_tx got %b exp 0", tx_valid); else n_pass++;
    n_total++; if (tx_data !== 8'h00) $display("FAIL mid_rst_txd got %h exp 00", tx_data); else n_pass++;
    n_total++; if (nIRQ !== 1'b1) $display("FAIL mid_rst_nirq got %b exp 1", nIRQ); else n_pass++;
    @(negedge CLKX4); Q = 1'b0; E = 1'b0; nCSEXTIO = 1'b1; RnW = 1'b1;
    @(negedge CLKX4); nRESET = 1'b1;
    rd(2'd2);
    n_total++; if (rdv !== 8'h00) $display("FAIL mid_no_commit got %h exp 00", rdv); else n_pass++;
    n_total++; if (st !== 0) $display("FAIL mid_wait_reset got %0d exp 0", st); else n_pass++;
    rd(2'd1);
    n_total++; if (rdv !== 8'h04) $display("FAIL mid_fifos_empty got %h exp 04", rdv); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_wait_ctrl();
    test_tx_overrun();
    test_rx_irq();
    test_rx_full_pop();
    test_tx_concurrent();
    test_reset_mid_stretch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
